keypad_scan: RTL and testbench

// - Scans the 4x4 keypad matrix and delivers debounced, single-shot key events to gomoku_main.
// - Drives the column lines one-cold and samples the row lines through a synchroniser.
// - Debounces over whole scan frames and emits one key_valid pulse per physical press.
// - Key code is {row[1:0], col[1:0]}: codes 8..15 select X, 0..7 select Y.

---
 rtl/keypad_scan_pkg.sv | 37 +++
 rtl/keypad_scan_debounce.sv | 116 +++++++++++
 rtl/keypad_scan.sv | 132 +++++++++++++
 tb/tb_keypad_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: column drive patterns,
// debounce FSM states and per-frame scan results.
package keypad_scan_pkg;

    localparam logic [3:0] KB_COL_0    = 4'b0111;
    localparam logic [3:0] KB_COL_1    = 4'b1011;
    localparam logic [3:0] KB_COL_2    = 4'b1101;
    localparam logic [3:0] KB_COL_3    = 4'b1110;
    localparam logic [3:0] KB_COL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        KB_IDLE    = 2'd0,
        KB_CONFIRM = 2'd1,
        KB_HELD    = 2'd2,
        KB_RELEASE = 2'd3
    } kb_state_t;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_kind_t;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        pat = KB_COL_0;
        case (idx)
            2'd0: pat = KB_COL_0;
            2'd1: pat = KB_COL_1;
            2'd2: pat = KB_COL_2;
            2'd3: pat = KB_COL_3;
            default: pat = KB_COL_0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Frame-level debounce FSM: turns a stream of per-frame scan results into
// single-shot press/release events. Evaluated only on frame_end.
module keypad_debounce
    import keypad_scan_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        frame_end,
    input  frame_kind_t frame_kind,
    input  logic [3:0]  frame_code,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        key_release,
    output kb_state_t   state_dbg
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    kb_state_t  state;
    logic [3:0] cand;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;

    assign cnt_inc   = cnt + 4'd1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= KB_IDLE;
            cand        <= 4'h0;
            cnt         <= 4'd0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_down    <= 1'b0;
            key_code    <= 4'h0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            // Halting the scan drops the key silently; key_code is left as is.
            if (clear) begin
                state    <= KB_IDLE;
                cand     <= 4'h0;
                cnt      <= 4'd0;
                key_down <= 1'b0;
            end else if (frame_end) begin
                case (state)
                    KB_IDLE: begin
                        if (frame_kind == FRAME_SINGLE) begin
                            cand <= frame_code;
                            cnt  <= 4'd1;
                            if (DEB == 4'd1) begin
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= KB_HELD;
                            end else begin
                                state <= KB_CONFIRM;
                            end
                        end
                    end
                    KB_CONFIRM: begin
                        if (frame_kind == FRAME_SINGLE) begin
                            if (frame_code == cand) begin
                                if (cnt_inc >= DEB) begin
                                    key_code  <= cand;
                                    key_valid <= 1'b1;
                                    key_down  <= 1'b1;
                                    state     <= KB_HELD;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end else begin
                                cand <= frame_code;
                                cnt  <= 4'd1;
                            end
                        end else begin
                            state <= KB_IDLE;
                        end
                    end
                    KB_HELD: begin
                        // MULTI counts as "still touched", so a second key never releases.
                        if (frame_kind == FRAME_NONE) begin
                            cnt <= 4'd1;
                            if (DEB == 4'd1) begin
                                key_down    <= 1'b0;
                                key_release <= 1'b1;
                                state       <= KB_IDLE;
                            end else begin
                                state <= KB_RELEASE;
                            end
                        end
                    end
                    KB_RELEASE: begin
                        if (frame_kind == FRAME_NONE) begin
                            if (cnt_inc >= DEB) begin
                                key_down    <= 1'b0;
                                key_release <= 1'b1;
                                state       <= KB_IDLE;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= KB_HELD;
                        end
                    end
                    default: state <= KB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one-cold column drive, row synchroniser and per-frame
// closure accumulator feeding the debounce FSM.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV        = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_release,
    output kb_state_t  debug_state
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             tick;
    logic [1:0]       acc_cnt;
    logic [3:0]       acc_code;
    logic             frame_end;
    frame_kind_t      frame_kind;
    logic [3:0]       frame_code;

    logic [2:0] col_hits;
    logic [1:0] col_first;
    logic       col_found;
    logic [2:0] total;
    logic [1:0] total_sat;
    logic [3:0] first_code;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= keyboard_row;
            row_sync <= row_meta;
        end
    end

    // Closures seen on the current column; lowest row wins as "first".
    always_comb begin
        col_hits  = 3'd0;
        col_first = 2'd0;
        col_found = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[3-r]) begin
                col_hits = col_hits + 3'd1;
                if (!col_found) begin
                    col_first = 2'(r);
                    col_found = 1'b1;
                end
            end
        end
        total      = {1'b0, acc_cnt} + col_hits;
        total_sat  = (total >= 3'd2) ? 2'd2 : total[1:0];
        first_code = (acc_cnt == 2'd0) ? {col_first, col_idx} : acc_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            col_idx      <= 2'd0;
            keyboard_col <= KB_COL_0;
            acc_cnt      <= 2'd0;
            acc_code     <= 4'h0;
            frame_end    <= 1'b0;
            frame_kind   <= FRAME_NONE;
            frame_code   <= 4'h0;
        end else begin
            frame_end <= 1'b0;
            if (!scan_en) begin
                div_cnt      <= '0;
                col_idx      <= 2'd0;
                keyboard_col <= KB_COL_IDLE;
                acc_cnt      <= 2'd0;
                acc_code     <= 4'h0;
            end else if (tick) begin
                div_cnt      <= '0;
                col_idx      <= col_idx + 2'd1;
                keyboard_col <= col_pattern(col_idx + 2'd1);
                if (col_idx == 2'd3) begin
                    frame_end  <= 1'b1;
                    frame_code <= first_code;
                    case (total_sat)
                        2'd0:    frame_kind <= FRAME_NONE;
                        2'd1:    frame_kind <= FRAME_SINGLE;
                        default: frame_kind <= FRAME_MULTI;
                    endcase
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_cnt  <= total_sat;
                    acc_code <= first_code;
                end
            end else begin
                div_cnt      <= div_cnt + 1'b1;
                keyboard_col <= col_pattern(col_idx);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!scan_en),
        .frame_end  (frame_end),
        .frame_kind (frame_kind),
        .frame_code (frame_code),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_down   (key_down),
        .key_release(key_release),
        .state_dbg  (debug_state)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix emulator, directed scenarios plus random
// press/glitch/chord traffic, with an event scoreboard.
module tb_keypad_scan;
    import keypad_scan_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic [3:0] keyboard_row;
    logic [3:0] keyboard_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;
    logic       key_release;
    kb_state_t  dbg_state;

    logic [15:0] pressed;
    logic [4:0]  exp_q[$];
    logic [4:0]  mon_exp;
    int          n_checks;
    int          n_fail;

    keypad_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .keyboard_row(keyboard_row),
        .keyboard_col(keyboard_col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_down    (key_down),
        .key_release (key_release),
        .debug_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a row line is pulled low when a pressed key sits on a driven column.
    always_comb begin
        keyboard_row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keyboard_col[3-c])
                    keyboard_row[3-r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() > n; i++) @(negedge clk);
        check(name, exp_q.size(), n);
    endtask

    // Returns at the first negedge after column 0 starts a new frame.
    task automatic wait_frame_start(input string name);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = keyboard_col;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (keyboard_col == 4'b0111 && prev == 4'b1110) found = 1'b1;
            prev = keyboard_col;
        end
        check(name, found, 1);
    endtask

    task automatic expect_press(input logic [3:0] code);
        exp_q.push_back({1'b0, code});
        exp_q.push_back({1'b1, code});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && key_release)
                check("valid_release_exclusive", 1, 0);
            if (key_valid || key_release) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got rel=%0d code=%0h, expected none",
                             key_release, key_code);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("event", {27'b0, key_release, key_code}, {27'b0, mon_exp});
                end
            end
        end
    end

    initial begin
        int lat;
        int rel_lat;
        logic [3:0] code_a;
        logic [3:0] code_b;
        n_checks = 0;
        n_fail   = 0;
        pressed  = 16'h0;
        scan_en  = 1'b1;
        rst_n    = 1'b0;

        cycles(3);
        check("reset_col", keyboard_col, 4'b0111);
        check("reset_valid", key_valid, 0);
        check("reset_release", key_release, 0);
        check("reset_down", key_down, 0);
        check("reset_code", key_code, 4'h0);
        check("reset_state", dbg_state, KB_IDLE);
        rst_n = 1'b1;
        cycles(5);

        // 1. Press A aligned to a frame start, then release aligned.
        wait_frame_start("t1_align_press");
        pressed[4'hA] = 1'b1;
        expect_press(4'hA);
        lat = -1;
        for (int i = 1; i <= 200 && lat < 0; i++) begin
            @(negedge clk);
            if (key_valid) lat = i;
        end
        check("t1_latency_le_67", (lat >= 1 && lat <= 67), 1);
        check("t1_code", key_code, 4'hA);
        cycles(100);
        check("t1_down_held", key_down, 1);
        check("t1_state_held", dbg_state, KB_HELD);
        cycles(150);
        wait_frame_start("t1_align_release");
        pressed[4'hA] = 1'b0;
        rel_lat = -1;
        for (int i = 1; i <= 200 && rel_lat < 0; i++) begin
            @(negedge clk);
            if (key_release) rel_lat = i;
        end
        check("t1_release_window", (rel_lat >= 60 && rel_lat <= 100), 1);
        check("t1_down_cleared", key_down, 0);
        wait_q(0, 10, "t1_events_drained");
        cycles(20);

        // 2. Glitch shorter than a frame.
        pressed[4'h3] = 1'b1;
        cycles(20);
        pressed[4'h3] = 1'b0;
        cycles(100);
        check("t2_down_low", key_down, 0);
        check("t2_code_kept", key_code, 4'hA);

        // 3. Hold 9, chord 1 on top, drop 1, release 9.
        expect_press(4'h9);
        pressed[4'h9] = 1'b1;
        wait_q(1, 150, "t3_valid_9");
        cycles(20);
        pressed[4'h1] = 1'b1;
        cycles(200);
        pressed[4'h1] = 1'b0;
        cycles(100);
        check("t3_still_down", key_down, 1);
        check("t3_code_9", key_code, 4'h9);
        pressed[4'h9] = 1'b0;
        wait_q(0, 200, "t3_release_9");
        cycles(20);

        // 4. Simultaneous 4+5 from idle.
        pressed[4'h4] = 1'b1;
        pressed[4'h5] = 1'b1;
        cycles(200);
        pressed[4'h4] = 1'b0;
        pressed[4'h5] = 1'b0;
        cycles(100);
        check("t4_down_low", key_down, 0);
        check("t4_state_idle", dbg_state, KB_IDLE);

        // 5. Release bounce on 7.
        expect_press(4'h7);
        pressed[4'h7] = 1'b1;
        wait_q(1, 150, "t5_valid_7");
        cycles(40);
        wait_frame_start("t5_align");
        pressed[4'h7] = 1'b0;
        cycles(40);
        pressed[4'h7] = 1'b1;
        cycles(40);
        check("t5_down_through_bounce", key_down, 1);
        pressed[4'h7] = 1'b0;
        wait_q(0, 200, "t5_release_7");
        cycles(20);

        // 6. Halt scanning while F is held, then re-enable.
        exp_q.push_back({1'b0, 4'hF});
        pressed[4'hF] = 1'b1;
        wait_q(0, 150, "t6_valid_f");
        cycles(10);
        scan_en = 1'b0;
        cycles(1);
        check("t6_col_idle", keyboard_col, 4'b1111);
        check("t6_down_dropped", key_down, 0);
        check("t6_state_idle", dbg_state, KB_IDLE);
        cycles(9);
        check("t6_col_still_idle", keyboard_col, 4'b1111);
        check("t6_code_kept", key_code, 4'hF);
        expect_press(4'hF);
        scan_en = 1'b1;
        wait_q(1, 150, "t6_fresh_valid_f");
        pressed[4'hF] = 1'b0;
        wait_q(0, 200, "t6_release_f");
        cycles(20);

        // 6b. Reset pulse while a press of 2 is being confirmed.
        wait_frame_start("t6b_align");
        pressed[4'h2] = 1'b1;
        cycles(40);
        check("t6b_confirming", dbg_state, KB_CONFIRM);
        rst_n = 1'b0;
        #1;
        check("t6b_reset_col", keyboard_col, 4'b0111);
        check("t6b_reset_code", key_code, 4'h0);
        check("t6b_reset_state", dbg_state, KB_IDLE);
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        pressed[4'h2] = 1'b0;
        cycles(150);
        check("t6b_down_low", key_down, 0);

        // Random traffic: clean presses, glitches and two-key chords.
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    code_a = 4'($urandom_range(0, 15));
                    expect_press(code_a);
                    pressed[code_a] = 1'b1;
                    cycles($urandom_range(100, 250));
                    pressed[code_a] = 1'b0;
                    wait_q(0, 200, "rand_single_drain");
                    check("rand_single_code", key_code, code_a);
                end
                1: begin
                    code_a = 4'($urandom_range(0, 15));
                    pressed[code_a] = 1'b1;
                    cycles($urandom_range(5, 20));
                    pressed[code_a] = 1'b0;
                    cycles(100);
                    check("rand_glitch_down", key_down, 0);
                end
                default: begin
                    code_a = 4'($urandom_range(0, 15));
                    code_b = code_a + 4'($urandom_range(1, 15));
                    pressed[code_a] = 1'b1;
                    pressed[code_b] = 1'b1;
                    cycles($urandom_range(100, 200));
                    pressed[code_a] = 1'b0;
                    pressed[code_b] = 1'b0;
                    cycles(100);
                    check("rand_chord_down", key_down, 0);
                end
            endcase
            cycles($urandom_range(20, 60));
        end

        cycles(50);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
